// File: rtl/conv_window_feeder.sv
// Streaming 6x6xchan_in window generator at stride 2 over a 6-row circular line buffer.
// Optional build macro CONV_WIN_OVERLAP_EN: keep accepting non-trigger pixels while a window waits.
module conv_window_feeder #(
   parameter int chan_in = 18,
   parameter int img_w   = 12,
   parameter int img_h   = 12
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [0:chan_in-1]            in_pixel,
   output logic                          win_valid,
   input  logic                          win_ready,
   output logic [0:chan_in-1][0:5][0:5]  image,
   output logic [7:0]                    win_row,
   output logic [7:0]                    win_col,
   output logic                          frame_done
);

   // state    | meaning
   // S_ACCEPT | streaming pixels into the line buffer
   // S_LOAD   | copying the triggered window into the image register
   // S_HOLD   | window presented, waiting for win_ready
   // S_DONE   | one-cycle frame end, counters cleared
   localparam logic [1:0] S_ACCEPT = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_HOLD   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int XW = (img_w > 1) ? $clog2(img_w) : 1;
   localparam int YW = (img_h > 1) ? $clog2(img_h) : 1;

   logic [1:0]          state;
   logic [XW-1:0]       x;
   logic [YW-1:0]       y;
   logic [2:0]          ws;
   logic [0:chan_in-1]  line_buf [0:5][0:img_w-1];

   logic [2:0]          pend_ws;
   logic [XW-1:0]       pend_x0;
   logic [7:0]          pend_row;
   logic [7:0]          pend_col;
   logic                last_pend;

   logic                acc;
   logic                pos_trig;
   logic                pos_last;
   logic                ready_st;
   logic [XW-1:0]       x_m5;
   logic [YW-1:0]       y_m5;
   logic [2:0]          rd_slot [0:5];
   logic [XW-1:0]       rd_col  [0:5];

   // Window row r lives in slot (ws_trigger - 5 + r) mod 6, i.e. (ws_trigger + 1 + r) mod 6.
   function automatic logic [2:0] slot_of(input logic [2:0] base, input int r);
      int s;
      s = int'(base) + r + 1;
      if (s >= 6) s = s - 6;
      return 3'(s);
   endfunction

   assign x_m5     = x - XW'(5);
   assign y_m5     = y - YW'(5);
   assign pos_trig = (x >= XW'(5)) && x[0] && (y >= YW'(5)) && y[0];
   assign pos_last = (x == XW'(img_w - 1)) && (y == YW'(img_h - 1));

`ifdef CONV_WIN_OVERLAP_EN
   // The pending window sits in its own register, so only triggers, the frame's last
   // pixel and anything past a pending last window must wait for the handshake.
   assign ready_st = (state == S_ACCEPT) ||
                     (((state == S_LOAD) || (state == S_HOLD)) &&
                      !(pos_trig || pos_last || last_pend));
`else
   assign ready_st = (state == S_ACCEPT);
`endif

   assign in_ready   = ready_st && !rst;
   assign frame_done = (state == S_DONE) && !rst;
   assign acc        = in_valid && in_ready;

   always_comb begin
      for (int r = 0; r < 6; r++) rd_slot[r] = slot_of(pend_ws, r);
      for (int k = 0; k < 6; k++) rd_col[k] = pend_x0 + XW'(k);
   end

   always_ff @(posedge clk) begin
      if (acc) line_buf[ws][x] <= in_pixel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x  <= '0;
         y  <= '0;
         ws <= '0;
      end else if (state == S_DONE) begin
         x  <= '0;
         y  <= '0;
         ws <= '0;
      end else if (acc) begin
         if (x == XW'(img_w - 1)) begin
            x  <= '0;
            ws <= (ws == 3'd5) ? 3'd0 : ws + 3'd1;
            y  <= (y == YW'(img_h - 1)) ? '0 : y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_ACCEPT;
         win_valid <= 1'b0;
         image     <= '0;
         win_row   <= '0;
         win_col   <= '0;
         pend_ws   <= '0;
         pend_x0   <= '0;
         pend_row  <= '0;
         pend_col  <= '0;
         last_pend <= 1'b0;
      end else begin
         case (state)
            S_ACCEPT: begin
               if (acc) begin
                  if (pos_trig) begin
                     pend_ws   <= ws;
                     pend_x0   <= x_m5;
                     pend_row  <= 8'(y_m5 >> 1);
                     pend_col  <= 8'(x_m5 >> 1);
                     last_pend <= pos_last;
                     state     <= S_LOAD;
                  end else if (pos_last) begin
                     state <= S_DONE;
                  end
               end
            end
            S_LOAD: begin
               for (int c = 0; c < chan_in; c++)
                  for (int r = 0; r < 6; r++)
                     for (int k = 0; k < 6; k++)
                        image[c][r][k] <= line_buf[rd_slot[r]][rd_col[k]][c];
               win_valid <= 1'b1;
               win_row   <= pend_row;
               win_col   <= pend_col;
               state     <= S_HOLD;
            end
            S_HOLD: begin
               if (win_ready) begin
                  win_valid <= 1'b0;
                  state     <= last_pend ? S_DONE : S_ACCEPT;
               end
            end
            S_DONE: begin
               last_pend <= 1'b0;
               state     <= S_ACCEPT;
            end
            default: state <= S_ACCEPT;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder: random and patterned frames compared against
// windows cut directly out of a stored frame image.
module tb_conv_window_feeder;

   localparam int CH   = 18;
   localparam int W    = 12;
   localparam int H    = 12;
   localparam int NPIX = W * H;
   localparam int NWIN = 16;

   typedef logic [0:CH-1][0:5][0:5] win_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [0:CH-1] in_pixel;
   logic          win_valid;
   logic          win_ready;
   win_t          image;
   logic [7:0]    win_row;
   logic [7:0]    win_col;
   logic          frame_done;

   conv_window_feeder #(.chan_in(CH), .img_w(W), .img_h(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pixel   (in_pixel),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .image      (image),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   logic [0:CH-1] pix_data [0:2*NPIX-1];
   int            acc_cyc  [0:2*NPIX-1];
   win_t          cap_img[$];
   int            cap_row[$];
   int            cap_col[$];
   int            take_cyc[$];
   int            done_cyc[$];
   logic          rdy_at_done[$];
   logic          rdy_after_done[$];
   win_t          hold_imgs[$];
   int            hold_rq[$];
   int            hold_cq[$];
   logic          hold_rdy[$];
   bit            timed_out;

   // Reference window: cut straight out of the stored frame.
   function automatic win_t exp_win(input int f, input int wr, input int wc);
      win_t w;
      for (int c = 0; c < CH; c++)
         for (int r = 0; r < 6; r++)
            for (int k = 0; k < 6; k++)
               w[c][r][k] = pix_data[f*NPIX + (2*wr + r)*W + 2*wc + k][c];
      return w;
   endfunction

   task automatic fill_random(input int f);
      for (int p = 0; p < NPIX; p++) pix_data[f*NPIX + p] = CH'($urandom);
   endtask

   task automatic fill_pattern(input int f);
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            for (int c = 0; c < CH; c++)
               pix_data[f*NPIX + yy*W + xx][c] = 1'((xx + 2*yy + c) & 1);
   endtask

   // Drives nframes of pix_data and records every handshake; no checking here.
   task automatic run_frames(input int nframes, input int gap_pct, input int hold_r,
                             input int hold_c, input int hold_len, input bit abort_on_hold);
      int  pi = 0;
      int  held = 0;
      int  budget = 0;
      bit  prev_done = 1'b0;
      bit  hold_now;
      cap_img.delete(); cap_row.delete(); cap_col.delete(); take_cyc.delete();
      done_cyc.delete(); rdy_at_done.delete(); rdy_after_done.delete();
      hold_imgs.delete(); hold_rq.delete(); hold_cq.delete(); hold_rdy.delete();
      timed_out = 1'b1;
      while (budget < 5000) begin
         @(negedge clk);
         cyc++;
         budget++;
         if (prev_done) rdy_after_done.push_back(in_ready);
         if (rdy_after_done.size() == nframes) begin
            in_valid  = 1'b0;
            win_ready = 1'b1;
            timed_out = 1'b0;
            break;
         end
         prev_done = frame_done;
         if (frame_done) begin
            done_cyc.push_back(cyc);
            rdy_at_done.push_back(in_ready);
         end
         hold_now = win_valid && (int'(win_row) == hold_r) && (int'(win_col) == hold_c) &&
                    (held < hold_len);
         if (hold_now) begin
            held++;
            hold_imgs.push_back(image);
            hold_rq.push_back(int'(win_row));
            hold_cq.push_back(int'(win_col));
            hold_rdy.push_back(in_ready);
            if (abort_on_hold && held == hold_len) begin
               win_ready = 1'b0;
               in_valid  = 1'b0;
               timed_out = 1'b0;
               break;
            end
         end
         win_ready = !hold_now;
         in_valid  = (pi < nframes*NPIX) && (int'($urandom_range(99)) >= gap_pct);
         in_pixel  = (pi < nframes*NPIX) ? pix_data[pi] : '0;
         #1;
         if (in_valid && in_ready) begin
            acc_cyc[pi] = cyc;
            pi++;
         end
         if (win_valid && win_ready) begin
            cap_img.push_back(image);
            cap_row.push_back(int'(win_row));
            cap_col.push_back(int'(win_col));
            take_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; win_ready = 1'b0; in_pixel = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      vecs++; if (win_valid !== 1'b0) begin errs++; $display("FAIL reset_win_valid got=%b want=0", win_valid); end
      vecs++; if (frame_done !== 1'b0) begin errs++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
      vecs++; if (image !== '0 || win_row !== 8'd0 || win_col !== 8'd0) begin
         errs++; $display("FAIL reset_window got row=%0d col=%0d img=%h want all 0", win_row, win_col, image); end
      rst = 1'b0;
      #1;
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL first_cycle_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_stream();
      win_t spec_w;
      fill_pattern(0);
      run_frames(1, 0, -1, -1, 0, 1'b0);
      vecs++; if (timed_out) begin errs++; $display("FAIL stream_timeout got=timeout want=finish"); end
      vecs++; if (cap_img.size() != NWIN) begin errs++; $display("FAIL stream_count got=%0d want=%0d", cap_img.size(), NWIN); end
      for (int i = 0; i < cap_img.size(); i++) begin
         vecs++; if (cap_row[i] !== (i%16)/4 || cap_col[i] !== i%4) begin
            errs++; $display("FAIL stream_index #%0d got=(%0d,%0d) want=(%0d,%0d)", i, cap_row[i], cap_col[i], (i%16)/4, i%4); end
         vecs++; if (cap_img[i] !== exp_win(0, (i%16)/4, i%4)) begin
            errs++; $display("FAIL stream_image #%0d got=%h want=%h", i, cap_img[i], exp_win(0, (i%16)/4, i%4)); end
      end
      if (cap_img.size() == NWIN) begin
         for (int c = 0; c < CH; c++)
            for (int r = 0; r < 6; r++)
               for (int k = 0; k < 6; k++)
                  spec_w[c][r][k] = 1'((6 + k + 2*(6 + r) + c) & 1);
         vecs++; if (cap_img[15] !== spec_w) begin errs++; $display("FAIL stream_last_wrap got=%h want=%h", cap_img[15], spec_w); end
         vecs++; if (take_cyc[0] !== acc_cyc[65] + 2) begin
            errs++; $display("FAIL stream_latency got=%0d want=%0d", take_cyc[0] - acc_cyc[65], 2); end
      end
      vecs++; if (done_cyc.size() != 1) begin errs++; $display("FAIL stream_done_count got=%0d want=1", done_cyc.size()); end
      if (done_cyc.size() == 1 && take_cyc.size() > 0) begin
         vecs++; if (done_cyc[0] !== take_cyc[take_cyc.size()-1] + 1) begin
            errs++; $display("FAIL stream_done_time got=%0d want=%0d", done_cyc[0], take_cyc[take_cyc.size()-1] + 1); end
      end
   endtask

   task automatic test_hold();
      fill_random(0);
      run_frames(1, 0, 1, 2, 10, 1'b0);
      vecs++; if (timed_out || hold_imgs.size() != 10) begin
         errs++; $display("FAIL hold_cycles got=%0d want=10 timeout=%0b", hold_imgs.size(), timed_out); end
      for (int i = 0; i < hold_imgs.size(); i++) begin
         vecs++; if (hold_imgs[i] !== exp_win(0, 1, 2) || hold_rq[i] !== 1 || hold_cq[i] !== 2) begin
            errs++; $display("FAIL hold_stable cyc%0d got=(%0d,%0d) %h want=(1,2) %h", i, hold_rq[i], hold_cq[i], hold_imgs[i], exp_win(0, 1, 2)); end
         vecs++; if (hold_rdy[i] !== 1'b0) begin errs++; $display("FAIL hold_in_ready cyc%0d got=%b want=0", i, hold_rdy[i]); end
      end
      vecs++; if (cap_img.size() != NWIN) begin errs++; $display("FAIL hold_count got=%0d want=%0d", cap_img.size(), NWIN); end
      for (int i = 0; i < cap_img.size(); i++) begin
         vecs++; if (cap_img[i] !== exp_win(0, (i%16)/4, i%4) || cap_row[i] !== (i%16)/4 || cap_col[i] !== i%4) begin
            errs++; $display("FAIL hold_window #%0d got=(%0d,%0d) %h want=%h", i, cap_row[i], cap_col[i], cap_img[i], exp_win(0, (i%16)/4, i%4)); end
      end
   endtask

   task automatic test_overlap();
      fill_random(0);
      run_frames(1, 0, 0, 0, 10, 1'b0);
      vecs++; if (timed_out || take_cyc.size() != NWIN) begin
         errs++; $display("FAIL overlap_count got=%0d want=%0d", take_cyc.size(), NWIN); end
      for (int i = 0; i < cap_img.size(); i++) begin
         vecs++; if (cap_img[i] !== exp_win(0, (i%16)/4, i%4)) begin
            errs++; $display("FAIL overlap_window #%0d got=%h want=%h", i, cap_img[i], exp_win(0, (i%16)/4, i%4)); end
      end
      if (take_cyc.size() > 0) begin
`ifdef CONV_WIN_OVERLAP_EN
         // (6,5) streams in during LOAD; (7,5) is a trigger and must wait for the take.
         vecs++; if (acc_cyc[66] !== acc_cyc[65] + 1) begin
            errs++; $display("FAIL overlap_stream_65 got=%0d want=%0d", acc_cyc[66], acc_cyc[65] + 1); end
         vecs++; if (acc_cyc[67] !== take_cyc[0] + 1) begin
            errs++; $display("FAIL overlap_block_trig got=%0d want=%0d", acc_cyc[67], take_cyc[0] + 1); end
`else
         vecs++; if (acc_cyc[66] !== take_cyc[0] + 1) begin
            errs++; $display("FAIL nooverlap_resume got=%0d want=%0d", acc_cyc[66], take_cyc[0] + 1); end
`endif
      end
   endtask

   task automatic test_reset_mid();
      fill_random(0);
      run_frames(1, 0, 0, 1, 5, 1'b1);
      vecs++; if (timed_out || win_valid !== 1'b1 || win_col !== 8'd1) begin
         errs++; $display("FAIL rstmid_pending got valid=%b col=%0d want valid=1 col=1", win_valid, win_col); end
      vecs++; if (done_cyc.size() != 0) begin errs++; $display("FAIL rstmid_no_done got=%0d want=0", done_cyc.size()); end
      rst = 1'b1;
      @(posedge clk); #1;
      vecs++; if (in_ready !== 1'b0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
         errs++; $display("FAIL rstmid_ctrl got rdy=%b val=%b done=%b want 0", in_ready, win_valid, frame_done); end
      vecs++; if (image !== '0 || win_row !== 8'd0 || win_col !== 8'd0) begin
         errs++; $display("FAIL rstmid_window got row=%0d col=%0d want 0", win_row, win_col); end
      @(negedge clk);
      rst = 1'b0; win_ready = 1'b1;
      #1;
      vecs++; if (in_ready !== 1'b1 || frame_done !== 1'b0) begin
         errs++; $display("FAIL rstmid_after got rdy=%b done=%b want rdy=1 done=0", in_ready, frame_done); end
      fill_random(0);
      run_frames(1, 10, -1, -1, 0, 1'b0);
      vecs++; if (timed_out || cap_img.size() != NWIN || done_cyc.size() != 1) begin
         errs++; $display("FAIL rstmid_fresh got win=%0d done=%0d want win=16 done=1", cap_img.size(), done_cyc.size()); end
      for (int i = 0; i < cap_img.size(); i++) begin
         vecs++; if (cap_img[i] !== exp_win(0, (i%16)/4, i%4)) begin
            errs++; $display("FAIL rstmid_window #%0d got=%h want=%h", i, cap_img[i], exp_win(0, (i%16)/4, i%4)); end
      end
   endtask

   task automatic test_back_to_back();
      fill_random(0);
      fill_random(1);
      run_frames(2, 30, -1, -1, 0, 1'b0);
      vecs++; if (timed_out || cap_img.size() != 2*NWIN) begin
         errs++; $display("FAIL b2b_count got=%0d want=%0d", cap_img.size(), 2*NWIN); end
      vecs++; if (done_cyc.size() != 2) begin errs++; $display("FAIL b2b_done_count got=%0d want=2", done_cyc.size()); end
      for (int i = 0; i < rdy_at_done.size(); i++) begin
         vecs++; if (rdy_at_done[i] !== 1'b0) begin errs++; $display("FAIL b2b_ready_in_done #%0d got=%b want=0", i, rdy_at_done[i]); end
      end
      for (int i = 0; i < rdy_after_done.size(); i++) begin
         vecs++; if (rdy_after_done[i] !== 1'b1) begin errs++; $display("FAIL b2b_ready_after_done #%0d got=%b want=1", i, rdy_after_done[i]); end
      end
      for (int i = 0; i < cap_img.size(); i++) begin
         vecs++; if (cap_img[i] !== exp_win(i/16, (i%16)/4, i%4) || cap_row[i] !== (i%16)/4 || cap_col[i] !== i%4) begin
            errs++; $display("FAIL b2b_window #%0d got=(%0d,%0d) %h want=%h", i, cap_row[i], cap_col[i], cap_img[i], exp_win(i/16, (i%16)/4, i%4)); end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_overlap();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
